uart_ram_cmd: RTL and testbench
===============================

Name: uart_ram_cmd

Overview:
Command decoder between the UART receiver and the 16x8 shadow RAM (Gowin_RAM16S) plus UART transmitter.
- Consumes received bytes as write/read commands.
- Drives the RAM address, data and write-enable pins.
- Returns read data, or an error code, to the transmitter.
- Replaces the free-running 1 s poll loop in top with an event-driven, byte-accurate protocol.

Parameters:
- RD_LAT, 1: cycles from ram_ad change to valid ram_dout; legal range 1-3.
- TIMEOUT_CYCLES, 27000000: max idle cycles between command byte and data byte (1 s at 27 MHz).
- ERR_BYTE, 8'h3F: reply for an illegal opcode or a timeout ('?').

Ports:
- clk  in  1  system clock, 27 MHz
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  received byte, valid when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- ram_ad  out  4  RAM address
- ram_di  out  8  RAM write data
- ram_wre  out  1  RAM write enable, one-cycle pulse
- ram_dout  in  8  RAM read data
- tx_ready  in  1  transmitter idle, can accept a byte
- tx_data  out  8  byte to transmit, held stable from tx_start until tx_ready rises again
- tx_start  out  1  one-cycle request; issued only while tx_ready=1
- busy  out  1  high in every state except IDLE
- err_overrun  out  1  sticky: a byte arrived while not accepting; cleared only by rst

Behaviour:
- Reset values (rst sampled high on a clk edge; same-cycle effect, all outputs):
  - ram_ad=0, ram_di=0, ram_wre=0
  - tx_data=0, tx_start=0, busy=0, err_overrun=0
  - state=IDLE, timeout counter=0
- Reset mid-command discards the partial command; no RAM write and no tx are issued.
- Command byte = {op[3:0], addr[3:0]}:
  - op=4'h1: write; the next byte is data.
  - op=4'h2: read.
  - any other op: error.
- States:
  - IDLE, on rx_valid:
    - op=1 -> WAIT_DATA; latch addr into ram_ad; clear timeout counter.
    - op=2 -> latch addr into ram_ad -> RD_WAIT.
    - else -> tx_data=ERR_BYTE -> TX_REQ.
  - WAIT_DATA:
    - rx_valid -> ram_di=rx_data, ram_wre=1 for exactly the next cycle -> WRITE.
    - Counter increments each cycle. On reaching TIMEOUT_CYCLES-1 with no byte: tx_data=ERR_BYTE -> TX_REQ, no write.
    - A byte and the timeout in the same cycle: the byte wins.
  - WRITE: ram_wre pulse cycle -> IDLE (ram_wre back to 0). Total 2 cycles from data strobe to IDLE.
  - RD_WAIT: wait RD_LAT cycles after ram_ad update; capture tx_data=ram_dout -> TX_REQ.
  - TX_REQ: when tx_ready=1, pulse tx_start one cycle -> TX_WAIT. While tx_ready=0, stay; tx_data is held.
  - TX_WAIT:
    - Wait for tx_ready=0 (acceptance), then tx_ready=1 -> IDLE.
    - If tx_ready is still 1 two cycles after tx_start, treat it as accepted-and-done -> IDLE.
- Overrun: rx_valid in any state other than IDLE or WAIT_DATA sets err_overrun. The byte is dropped and the state is unaffected.
- ram_ad holds its last value in IDLE. ram_wre is never high outside WRITE.
- Read latency: command strobe -> tx_start = 1 + RD_LAT + 1 cycles, given tx_ready=1 (3 cycles at RD_LAT=1).
- Timeout counter is 25 bits, saturating; no wrap-around.

Optional Feature:
- Macro: UART_RAM_CMD_WRITE_ACK_EN
- Defined: after the WRITE state, tx_data=8'h06 (ACK) -> TX_REQ/TX_WAIT before IDLE. Write latency therefore includes one transmitted byte.
- Undefined: a write returns directly to IDLE with no reply; 8'h06 is never generated.

Test Plan:
- Write then read: rx 8'h15, 8'hA7, then 8'h25 -> ram_wre pulses once with ram_ad=5, ram_di=A7; the read yields tx_start with tx_data=8'hA7 exactly 3 cycles after the 8'h25 strobe (RD_LAT=1, tx_ready=1).
- Illegal op: rx 8'h70 -> tx_data=8'h3F with one tx_start; RAM untouched; busy returns low after tx_ready cycles.
- Timeout: TIMEOUT_CYCLES=100, rx 8'h13 and no data byte -> tx_data=8'h3F at cycle 100 after the strobe; ram_wre never asserted; a following rx 8'h23 reads the old value of address 3.
- Backpressure: tx_ready=0 held for 50 cycles during a read of address 0 -> tx_start stays low and tx_data stays stable; tx_start fires on the first cycle tx_ready=1.
- Overrun: a second rx_valid 8'h22 during TX_WAIT -> err_overrun=1 and stays set; no second reply; rst clears it to 0.
- Reset mid-command: rst during WAIT_DATA after rx 8'h1F -> no write to address F; all outputs at reset values the next cycle. With UART_RAM_CMD_WRITE_ACK_EN defined, a complete write emits tx_data=8'h06.

Source files
------------

// File: rtl/uart_ram_cmd.sv
// uart_ram_cmd: byte-command decoder between the UART receiver, the 16x8
// shadow RAM and the UART transmitter.
//   cmd byte {op,addr}: op=1 write (next byte is data), op=2 read, other -> '?'
// Optional macro UART_RAM_CMD_WRITE_ACK_EN: a completed write replies 8'h06.
module uart_ram_cmd #(
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned TIMEOUT_CYCLES = 27000000,
  parameter logic [7:0]  ERR_BYTE       = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] ram_ad,
  output logic [7:0] ram_di,
  output logic       ram_wre,
  input  logic [7:0] ram_dout,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       err_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_WRITE,
    S_RD_WAIT,
    S_TX_REQ,
    S_TX_WAIT
  } state_e;

  localparam logic [24:0] TO_LAST = 25'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  RD_LAST = 2'(RD_LAT);
`ifdef UART_RAM_CMD_WRITE_ACK_EN
  localparam logic [7:0]  ACK_BYTE = 8'h06;
`endif

  state_e      state_q, state_d;
  logic [3:0]  ram_ad_q, ram_ad_d;
  logic [7:0]  ram_di_q, ram_di_d;
  logic        ram_wre_q, ram_wre_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        busy_q, busy_d;
  logic        err_overrun_q, err_overrun_d;
  logic [24:0] to_cnt_q, to_cnt_d;   // idle cycles waiting for the data byte
  logic [1:0]  rd_cnt_q, rd_cnt_d;   // cycles since ram_ad was updated for a read
  logic        txw_cnt_q, txw_cnt_d; // cycles in TX_WAIT without seeing tx_ready low
  logic        seen_low_q, seen_low_d;

  // Next-state and next-output logic for the command FSM.
  always_comb begin
    // NOTE: every _d starts from its hold value so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    ram_ad_d      = ram_ad_q;
    ram_di_d      = ram_di_q;
    ram_wre_d     = 1'b0;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    to_cnt_d      = to_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    txw_cnt_d     = txw_cnt_q;
    seen_low_d    = seen_low_q;
    err_overrun_d = err_overrun_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data[7:4])
            4'h1: begin
              ram_ad_d = rx_data[3:0];
              to_cnt_d = '0;
              state_d  = S_WAIT_DATA;
            end
            4'h2: begin
              ram_ad_d = rx_data[3:0];
              rd_cnt_d = '0;
              state_d  = S_RD_WAIT;
            end
            default: begin
              tx_data_d = ERR_BYTE;
              state_d   = S_TX_REQ;
            end
          endcase
        end
      end
      S_WAIT_DATA: begin
        // A data byte beats a timeout landing in the same cycle.
        if (rx_valid) begin
          ram_di_d  = rx_data;
          ram_wre_d = 1'b1;
          state_d   = S_WRITE;
        end else if (to_cnt_q == TO_LAST) begin
          tx_data_d = ERR_BYTE;
          state_d   = S_TX_REQ;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 25'd1;
        end
      end
      S_WRITE: begin
`ifdef UART_RAM_CMD_WRITE_ACK_EN
        tx_data_d = ACK_BYTE;
        state_d   = S_TX_REQ;
`else
        state_d   = S_IDLE;
`endif
      end
      S_RD_WAIT: begin
        // ram_dout becomes valid RD_LAT cycles after ram_ad, sample one cycle later.
        if (rd_cnt_q == RD_LAST) begin
          tx_data_d = ram_dout;
          state_d   = S_TX_REQ;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end
      S_TX_REQ: begin
        if (tx_ready) begin
          tx_start_d = 1'b1;
          txw_cnt_d  = 1'b0;
          seen_low_d = 1'b0;
          state_d    = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        // Done once tx_ready has dropped and risen again, or if it never
        // dropped within two cycles of tx_start.
        if (!tx_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q || txw_cnt_q) begin
          state_d = S_IDLE;
        end else begin
          txw_cnt_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bytes arriving while a command is in flight are dropped and flagged.
    if (rx_valid && (state_q != S_IDLE) && (state_q != S_WAIT_DATA)) begin
      err_overrun_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= S_IDLE;
      ram_ad_q      <= '0;
      ram_di_q      <= '0;
      ram_wre_q     <= 1'b0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_overrun_q <= 1'b0;
      to_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      txw_cnt_q     <= 1'b0;
      seen_low_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ram_ad_q      <= ram_ad_d;
      ram_di_q      <= ram_di_d;
      ram_wre_q     <= ram_wre_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      err_overrun_q <= err_overrun_d;
      to_cnt_q      <= to_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      txw_cnt_q     <= txw_cnt_d;
      seen_low_q    <= seen_low_d;
    end
  end

  assign ram_ad      = ram_ad_q;
  assign ram_di      = ram_di_q;
  assign ram_wre     = ram_wre_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign busy        = busy_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_ram_cmd.sv
// Testbench for uart_ram_cmd: transaction table plus directed corner sequences.
// Includes a 1-cycle-latency RAM model and a transmitter model.
module tb_uart_ram_cmd;

  localparam int TO = 100;
`ifdef UART_RAM_CMD_WRITE_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [3:0] ram_ad;
  logic [7:0] ram_di;
  logic       ram_wre;
  logic [7:0] ram_dout = 8'h00;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       err_overrun;

  uart_ram_cmd #(
    .RD_LAT(1),
    .TIMEOUT_CYCLES(TO),
    .ERR_BYTE(8'h3F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .ram_ad(ram_ad),
    .ram_di(ram_di),
    .ram_wre(ram_wre),
    .ram_dout(ram_dout),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .busy(busy),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RAM model: registered read, one cycle after the address.
  logic [7:0] mem [16] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87,
                           8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h8F};
  int         wr_count = 0;
  logic [3:0] last_wr_ad = 4'h0;
  logic [7:0] last_wr_di = 8'h00;

  always @(posedge clk) begin
    if (ram_wre === 1'b1) begin
      mem[ram_ad] <= ram_di;
      wr_count    <= wr_count + 1;
      last_wr_ad  <= ram_ad;
      last_wr_di  <= ram_di;
    end
    ram_dout <= mem[ram_ad];
  end

  // Transmitter model: busy for 3 cycles after each tx_start, or forced busy.
  int         tx_count = 0;
  logic [7:0] last_tx = 8'h00;
  int         tx_viol = 0;
  bit         tx_block = 1'b0;
  int         tx_busy = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        tx_count++;
        last_tx = tx_data;
        if (!tx_ready) tx_viol++;
        tx_busy = 3;
      end else if (tx_busy > 0) begin
        tx_busy--;
      end
      tx_ready = !tx_block && (tx_busy == 0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    check({name, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ram_ad"},   {28'b0, ram_ad},     32'd0);
    check({name, "_ram_di"},   {24'b0, ram_di},     32'd0);
    check({name, "_ram_wre"},  {31'b0, ram_wre},    32'd0);
    check({name, "_tx_data"},  {24'b0, tx_data},    32'd0);
    check({name, "_tx_start"}, {31'b0, tx_start},   32'd0);
    check({name, "_busy"},     {31'b0, busy},       32'd0);
    check({name, "_overrun"},  {31'b0, err_overrun}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    bit         has_data;
    logic [7:0] data;
    bit         exp_tx;
    logic [7:0] exp_byte;
    bit         exp_wr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, wr0, lat, to_at, bad, fired;
    logic [7:0] got;

    vecs[0]  = '{8'h15, 1'b1, 8'hA7, ACK_EN, 8'h06, 1'b1};
    vecs[1]  = '{8'h25, 1'b0, 8'h00, 1'b1,   8'hA7, 1'b0};
    vecs[2]  = '{8'h70, 1'b0, 8'h00, 1'b1,   8'h3F, 1'b0};
    vecs[3]  = '{8'h2A, 1'b0, 8'h00, 1'b1,   8'h8A, 1'b0};
    vecs[4]  = '{8'h1C, 1'b1, 8'h00, ACK_EN, 8'h06, 1'b1};
    vecs[5]  = '{8'h2C, 1'b0, 8'h00, 1'b1,   8'h00, 1'b0};
    vecs[6]  = '{8'h1F, 1'b1, 8'hFF, ACK_EN, 8'h06, 1'b1};
    vecs[7]  = '{8'h2F, 1'b0, 8'h00, 1'b1,   8'hFF, 1'b0};
    vecs[8]  = '{8'h00, 1'b0, 8'h00, 1'b1,   8'h3F, 1'b0};
    vecs[9]  = '{8'hF2, 1'b0, 8'h00, 1'b1,   8'h3F, 1'b0};
    vecs[10] = '{8'h20, 1'b0, 8'h00, 1'b1,   8'h80, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Transaction table
    for (int i = 0; i < 11; i++) begin
      string nm;
      nm  = $sformatf("vec%0d", i);
      tx0 = tx_count;
      wr0 = wr_count;
      send_byte(vecs[i].cmd);
      if (vecs[i].has_data) send_byte(vecs[i].data);
      wait_idle(nm);
      repeat (2) @(negedge clk);
      check({nm, "_tx_cnt"}, 32'(tx_count - tx0), 32'(vecs[i].exp_tx));
      if (vecs[i].exp_tx) check({nm, "_tx_byte"}, {24'b0, last_tx}, {24'b0, vecs[i].exp_byte});
      check({nm, "_wr_cnt"}, 32'(wr_count - wr0), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) begin
        check({nm, "_wr_ad"}, {28'b0, last_wr_ad}, {28'b0, vecs[i].cmd[3:0]});
        check({nm, "_wr_di"}, {24'b0, last_wr_di}, {24'b0, vecs[i].data});
      end
    end

    // Read latency: strobe edge to tx_start edge is 3 cycles
    @(negedge clk);
    rx_data = 8'h25; rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    lat = -1; got = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (tx_start === 1'b1 && lat < 0) begin
        lat = k;
        got = tx_data;
      end
    end
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_latency_data", {24'b0, got}, 32'hA7);
    wait_idle("rd_latency");

    // Timeout: no data byte after a write command
    wr0 = wr_count;
    @(negedge clk);
    rx_data = 8'h13; rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    to_at = -1;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk);
      #1;
      if (tx_data === 8'h3F && to_at < 0) to_at = k;
    end
    check("timeout_cycle", 32'(to_at), 32'd100);
    wait_idle("timeout");
    check("timeout_no_write", 32'(wr_count - wr0), 32'd0);
    send_byte(8'h23);
    wait_idle("timeout_read");
    check("timeout_old_value", {24'b0, last_tx}, 32'h83);

    // Data byte in the very cycle the timeout would fire: the byte wins
    wr0 = wr_count; tx0 = tx_count;
    @(negedge clk);
    rx_data = 8'h14; rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (99) @(posedge clk);
    #1 rx_data = 8'h5A; rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    wait_idle("to_edge");
    repeat (2) @(negedge clk);
    check("to_edge_wr_cnt", 32'(wr_count - wr0), 32'd1);
    check("to_edge_wr_ad", {28'b0, last_wr_ad}, 32'h4);
    check("to_edge_wr_di", {24'b0, last_wr_di}, 32'h5A);
    check("to_edge_tx_cnt", 32'(tx_count - tx0), 32'(ACK_EN));

    // Backpressure: transmitter not ready for 50 cycles
    tx_block = 1'b1;
    repeat (2) @(negedge clk);
    tx0 = tx_count;
    @(negedge clk);
    rx_data = 8'h20; rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    bad = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (tx_start !== 1'b0) bad++;
      if (k >= 3 && tx_data !== 8'h80) bad++;
    end
    check("bp_stall", 32'(bad), 32'd0);
    check("bp_busy", {31'b0, busy}, 32'd1);
    tx_block = 1'b0;
    fired = -1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (tx_ready && fired < 0) fired = (tx_start === 1'b1) ? 1 : 0;
    end
    check("bp_release", 32'(fired), 32'd1);
    wait_idle("bp");
    check("bp_tx_cnt", 32'(tx_count - tx0), 32'd1);
    check("bp_tx_byte", {24'b0, last_tx}, 32'h80);

    // Overrun: second byte during TX_WAIT
    tx0 = tx_count;
    send_byte(8'h21);
    for (int k = 0; k < 20; k++) begin
      if (tx_start === 1'b1) break;
      @(negedge clk);
    end
    rx_data = 8'h22; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_idle("overrun");
    repeat (5) @(negedge clk);
    check("overrun_set", {31'b0, err_overrun}, 32'd1);
    check("overrun_tx_cnt", 32'(tx_count - tx0), 32'd1);
    check("overrun_tx_byte", {24'b0, last_tx}, 32'h81);
    repeat (10) @(negedge clk);
    check("overrun_sticky", {31'b0, err_overrun}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 check("overrun_rst", {31'b0, err_overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in WAIT_DATA discards the write
    wr0 = wr_count; tx0 = tx_count;
    send_byte(8'h1F);
    repeat (3) @(negedge clk);
    check("midrst_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_wr_cnt", 32'(wr_count - wr0), 32'd0);
    check("midrst_tx_cnt", 32'(tx_count - tx0), 32'd0);
    check("midrst_mem_f", {24'b0, mem[15]}, 32'hFF);

    check("tx_start_only_when_ready", 32'(tx_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
